// File: rtl/bus_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM states, bus owner and the registered request.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arbiterState_;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } busOwner_;

    typedef struct packed {
        logic [31:0] address;
        logic        writeEnable;
        logic [31:0] writeData;
        logic [3:0]  byteEnable;
    } memoryRequest_;

    // Bits needed to hold 0..maxCount; never narrower than one bit.
    function automatic int unsigned streakCountWidth(input int unsigned maxCount);
        return (maxCount < 2) ? 1 : $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/arbiter_streak_counter.sv
// Saturating up-counter with synchronous clear; counts consecutive data grants that made fetch wait.
module arbiter_streak_counter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_COUNT   = 4,
    parameter int unsigned COUNT_WIDTH = streakCountWidth(MAX_COUNT)
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   increment,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (increment && (count != COUNT_WIDTH'(MAX_COUNT))) begin
            count <= count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one memory port between fetch and data requesters; data wins unless BUS_ARBITER_STREAK_GUARD_EN forces fetch.
// Latency: grant in IDLE, memRequestValid next cycle, owner response combinational with memResponseValid (3 cycles min).
// Backpressure: one transaction in flight; RequestReady only in IDLE, memRequestValid held until memRequestReady.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        instrRequestValid,
    input  logic [31:0] instrAddress,
    input  logic        instrFlush,
    output logic        instrRequestReady,
    output logic        instrResponseValid,
    output logic [31:0] instrResponseData,
    input  logic        dataRequestValid,
    input  logic [31:0] dataAddress,
    input  logic        dataWriteEnable,
    input  logic [31:0] dataWriteData,
    input  logic [3:0]  dataByteEnable,
    output logic        dataRequestReady,
    output logic        dataResponseValid,
    output logic [31:0] dataResponseData,
    output logic        memRequestValid,
    input  logic        memRequestReady,
    output logic [31:0] memAddress,
    output logic        memWriteEnable,
    output logic [31:0] memWriteData,
    output logic [3:0]  memByteEnable,
    input  logic        memResponseValid,
    input  logic [31:0] memResponseData,
    output logic        busy
);

    arbiterState_  state, nextState;
    busOwner_      owner;
    memoryRequest_ request;
    logic          dropFlag;
    logic          instrWanted;
    logic          forceInstr;
    logic          grantData;
    logic          grantInstr;
    logic          responseHit;

    if (MAX_DATA_STREAK < 1) begin : gBadStreak
        $error("MAX_DATA_STREAK must be at least 1");
    end

    // A flushed fetch must never be accepted, so it does not count as pending.
    assign instrWanted = instrRequestValid && !instrFlush;

`ifdef BUS_ARBITER_STREAK_GUARD_EN
    localparam int unsigned StreakWidth = streakCountWidth(MAX_DATA_STREAK);
    logic [StreakWidth-1:0] streakCount;

    arbiter_streak_counter #(
        .MAX_COUNT  (MAX_DATA_STREAK),
        .COUNT_WIDTH(StreakWidth)
    ) u_streakCounter (
        .clock    (clock),
        .resetN   (resetN),
        .increment(grantData && instrWanted),
        .clear    (grantInstr || ((state == ARB_IDLE) && !instrRequestValid)),
        .count    (streakCount)
    );

    assign forceInstr = (streakCount == StreakWidth'(MAX_DATA_STREAK)) && dataRequestValid && instrWanted;
`else
    assign forceInstr = 1'b0;
`endif

    always_comb begin
        nextState  = state;
        grantData  = 1'b0;
        grantInstr = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (dataRequestValid && !forceInstr) begin
                    grantData = 1'b1;
                end else if (instrWanted) begin
                    grantInstr = 1'b1;
                end
                if (grantData || grantInstr) begin
                    nextState = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (memRequestReady) begin
                    nextState = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (memResponseValid) begin
                    nextState = ARB_IDLE;
                end
            end
            default: nextState = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= ARB_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= nextState;
            busy  <= (nextState != ARB_IDLE);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            request <= '0;
            owner   <= OWNER_INSTR;
        end else if (grantData) begin
            request <= '{address: dataAddress, writeEnable: dataWriteEnable,
                         writeData: dataWriteData, byteEnable: dataByteEnable};
            owner   <= OWNER_DATA;
        end else if (grantInstr) begin
            request <= '{address: instrAddress, writeEnable: 1'b0,
                         writeData: 32'h0, byteEnable: 4'h0};
            owner   <= OWNER_INSTR;
        end
    end

    // The memory side still completes a flushed fetch; only its response is suppressed.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            dropFlag <= 1'b0;
        end else if (nextState == ARB_IDLE) begin
            dropFlag <= 1'b0;
        end else if ((state != ARB_IDLE) && (owner == OWNER_INSTR) && instrFlush) begin
            dropFlag <= 1'b1;
        end
    end

    assign responseHit = (state == ARB_WAIT) && memResponseValid;

    assign instrRequestReady  = grantInstr;
    assign dataRequestReady   = grantData;
    assign instrResponseValid = responseHit && (owner == OWNER_INSTR) && !dropFlag && !instrFlush;
    assign dataResponseValid  = responseHit && (owner == OWNER_DATA);
    assign instrResponseData  = instrResponseValid ? memResponseData : 32'h0;
    assign dataResponseData   = dataResponseValid ? memResponseData : 32'h0;

    assign memRequestValid = (state == ARB_ISSUE);
    assign memAddress      = request.address;
    assign memWriteEnable  = request.writeEnable;
    assign memWriteData    = request.writeData;
    assign memByteEnable   = request.byteEnable;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table, multi-cycle corner sequences, then randomized traffic against a transaction model.
module tb_bus_arbiter;

`ifdef BUS_ARBITER_STREAK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int MAXS = 4;

    logic        clock = 1'b0;
    logic        resetN;
    logic        instrRequestValid, instrFlush, instrRequestReady, instrResponseValid;
    logic [31:0] instrAddress, instrResponseData;
    logic        dataRequestValid, dataWriteEnable, dataRequestReady, dataResponseValid;
    logic [31:0] dataAddress, dataWriteData, dataResponseData;
    logic [3:0]  dataByteEnable, memByteEnable;
    logic        memRequestValid, memRequestReady, memWriteEnable, memResponseValid, busy;
    logic [31:0] memAddress, memWriteData, memResponseData;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    bus_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
        .clock(clock), .resetN(resetN),
        .instrRequestValid(instrRequestValid), .instrAddress(instrAddress), .instrFlush(instrFlush),
        .instrRequestReady(instrRequestReady), .instrResponseValid(instrResponseValid),
        .instrResponseData(instrResponseData),
        .dataRequestValid(dataRequestValid), .dataAddress(dataAddress), .dataWriteEnable(dataWriteEnable),
        .dataWriteData(dataWriteData), .dataByteEnable(dataByteEnable), .dataRequestReady(dataRequestReady),
        .dataResponseValid(dataResponseValid), .dataResponseData(dataResponseData),
        .memRequestValid(memRequestValid), .memRequestReady(memRequestReady), .memAddress(memAddress),
        .memWriteEnable(memWriteEnable), .memWriteData(memWriteData), .memByteEnable(memByteEnable),
        .memResponseValid(memResponseValid), .memResponseData(memResponseData), .busy(busy)
    );

    typedef struct {
        logic        iv;
        logic        fl;
        logic        dv;
        logic        we;
        logic [31:0] rsp;
        logic        expI;
        logic        expD;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [159:0] actual, input logic [159:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs();
        instrRequestValid = 0; instrFlush = 0; instrAddress = 0;
        dataRequestValid = 0; dataAddress = 0; dataWriteEnable = 0; dataWriteData = 0; dataByteEnable = 0;
        memRequestReady = 0; memResponseValid = 0; memResponseData = 0;
    endtask

    function automatic logic [159:0] allOutputs();
        return {instrRequestReady, instrResponseValid, instrResponseData, dataRequestReady,
                dataResponseValid, dataResponseData, memRequestValid, memAddress, memWriteEnable,
                memWriteData, memByteEnable, busy};
    endfunction

    // Randomized-phase model state
    bit          outstanding, issued, dropped, ownerI;
    logic [31:0] expAddr, expWd;
    logic        expWe;
    logic [3:0]  expBe;
    int          streak;
    bit          memPending;
    int          memDelay;
    bit          iPend, dPend;

    initial begin
        logic [31:0] dAddrNow;
        int          ackCount;
        bit          expIR, expDR, ivEff, respNow;

        vecs[0] = '{iv: 1, fl: 0, dv: 0, we: 0, rsp: 32'h0000_0013, expI: 1, expD: 0};
        vecs[1] = '{iv: 0, fl: 0, dv: 1, we: 0, rsp: 32'hA5A5_0001, expI: 0, expD: 1};
        vecs[2] = '{iv: 1, fl: 0, dv: 1, we: 1, rsp: 32'h0000_0000, expI: 0, expD: 1};
        vecs[3] = '{iv: 1, fl: 1, dv: 0, we: 0, rsp: 32'h7777_0000, expI: 0, expD: 0};
        vecs[4] = '{iv: 1, fl: 1, dv: 1, we: 1, rsp: 32'h0000_0BAD, expI: 0, expD: 1};
        vecs[5] = '{iv: 0, fl: 0, dv: 0, we: 0, rsp: 32'h1111_2222, expI: 0, expD: 0};
        vecs[6] = '{iv: 1, fl: 0, dv: 0, we: 0, rsp: 32'hFFFF_FFFF, expI: 1, expD: 0};

        idleInputs();
        resetN = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", allOutputs(), '0);
        cyc();
        resetN = 1;

        // Vector table: one transaction per entry with zero-wait memory
        for (int i = 0; i < 7; i++) begin
            cyc();
            instrRequestValid = vecs[i].iv; instrFlush = vecs[i].fl; instrAddress = 32'h8000_0000;
            dataRequestValid = vecs[i].dv; dataWriteEnable = vecs[i].we;
            dAddrNow = 32'h1000_0040 + i; dataAddress = dAddrNow;
            dataWriteData = 32'hD0D0_0000 + i; dataByteEnable = 4'hF;
            @(negedge clock);
            check($sformatf("vec%0d_instrReady", i), instrRequestReady, vecs[i].expI);
            check($sformatf("vec%0d_dataReady", i), dataRequestReady, vecs[i].expD);
            cyc();
            idleInputs();
            memRequestReady = 1;
            @(negedge clock);
            check($sformatf("vec%0d_memReqValid", i), memRequestValid, vecs[i].expI | vecs[i].expD);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].expI | vecs[i].expD);
            if (vecs[i].expI) check($sformatf("vec%0d_memAddr", i), memAddress, 32'h8000_0000);
            if (vecs[i].expD) check($sformatf("vec%0d_memAddr", i), memAddress, dAddrNow);
            if (vecs[i].expD) check($sformatf("vec%0d_memWe", i), memWriteEnable, vecs[i].we);
            cyc();
            memRequestReady = 0; memResponseValid = 1; memResponseData = vecs[i].rsp;
            @(negedge clock);
            check($sformatf("vec%0d_instrRespValid", i), instrResponseValid, vecs[i].expI);
            check($sformatf("vec%0d_dataRespValid", i), dataResponseValid, vecs[i].expD);
            if (vecs[i].expI) check($sformatf("vec%0d_instrData", i), instrResponseData, vecs[i].rsp);
            if (vecs[i].expD) check($sformatf("vec%0d_dataData", i), dataResponseData, vecs[i].rsp);
            cyc();
            memResponseValid = 0;
            @(negedge clock);
            check($sformatf("vec%0d_busyDone", i), busy, 1'b0);
        end

        // Store with three stall cycles on memRequestReady
        cyc();
        dataRequestValid = 1; dataWriteEnable = 1; dataWriteData = 32'hDEAD_BEEF;
        dataByteEnable = 4'hF; dataAddress = 32'h0000_2000;
        @(negedge clock);
        check("store_ready", dataRequestReady, 1'b1);
        for (int s = 0; s < 4; s++) begin
            cyc();
            if (s == 0) idleInputs();
            memRequestReady = (s == 3);
            @(negedge clock);
            check($sformatf("store_issue%0d_valid", s), memRequestValid, 1'b1);
            check($sformatf("store_issue%0d_wdata", s), memWriteData, 32'hDEAD_BEEF);
            check($sformatf("store_issue%0d_be", s), memByteEnable, 4'hF);
            check($sformatf("store_issue%0d_we", s), memWriteEnable, 1'b1);
        end
        ackCount = 0;
        for (int s = 0; s < 4; s++) begin
            cyc();
            memRequestReady = 0;
            memResponseValid = (s == 1);
            @(negedge clock);
            ackCount += int'(dataResponseValid);
        end
        check("store_ack_count", ackCount, 1);

        // Fetch flushed while waiting, then a clean fetch, then flush coincident with the response
        cyc(); instrRequestValid = 1; instrAddress = 32'h0000_0100;
        @(negedge clock); check("flush_grant", instrRequestReady, 1'b1);
        cyc(); instrRequestValid = 0; memRequestReady = 1;
        cyc(); memRequestReady = 0; instrFlush = 1;
        @(negedge clock); check("flush_wait_noresp", instrResponseValid, 1'b0);
        cyc(); instrFlush = 0; memResponseValid = 1; memResponseData = 32'h1234_5678;
        @(negedge clock);
        check("flush_dropped", instrResponseValid, 1'b0);
        check("flush_busy", busy, 1'b1);
        cyc(); memResponseValid = 0; instrRequestValid = 1; instrAddress = 32'h0000_0104;
        @(negedge clock);
        check("after_flush_busy", busy, 1'b0);
        check("after_flush_grant", instrRequestReady, 1'b1);
        cyc(); instrRequestValid = 0; memRequestReady = 1;
        cyc(); memRequestReady = 0; memResponseValid = 1; memResponseData = 32'hCAFE_0001;
        @(negedge clock);
        check("after_flush_resp", instrResponseValid, 1'b1);
        check("after_flush_data", instrResponseData, 32'hCAFE_0001);
        cyc(); memResponseValid = 0; instrRequestValid = 1;
        @(negedge clock); check("sameflush_grant", instrRequestReady, 1'b1);
        cyc(); instrRequestValid = 0; memRequestReady = 1;
        cyc(); memRequestReady = 0; memResponseValid = 1; instrFlush = 1;
        @(negedge clock); check("sameflush_dropped", instrResponseValid, 1'b0);
        cyc(); memResponseValid = 0; instrFlush = 0;

        // Both requesters continuously valid
        for (int k = 0; k < 10; k++) begin
            bit wantI;
            wantI = GUARD && ((k % (MAXS + 1)) == MAXS);
            cyc();
            memResponseValid = 0;
            instrRequestValid = 1; dataRequestValid = 1; dataWriteEnable = 0;
            @(negedge clock);
            check($sformatf("contend%0d_instrReady", k), instrRequestReady, wantI);
            check($sformatf("contend%0d_dataReady", k), dataRequestReady, !wantI);
            cyc(); memRequestReady = 1;
            cyc(); memRequestReady = 0; memResponseValid = 1;
        end
        cyc();
        idleInputs();

        // Asynchronous reset in ARB_WAIT, then a stray response
        cyc(); instrRequestValid = 1; instrAddress = 32'h0000_0200;
        @(negedge clock); check("rst_grant", instrRequestReady, 1'b1);
        cyc(); instrRequestValid = 0; memRequestReady = 1;
        cyc(); memRequestReady = 0;
        #2 resetN = 0;
        #1 check("rst_midwait_outputs", allOutputs(), '0);
        cyc(); resetN = 1;
        cyc(); memResponseValid = 1; memResponseData = 32'h5555_AAAA;
        @(negedge clock);
        check("rst_stray_outputs", allOutputs(), '0);
        cyc(); memResponseValid = 0; instrRequestValid = 1;
        @(negedge clock); check("rst_idle_grant", instrRequestReady, 1'b1);
        cyc(); instrRequestValid = 0; memRequestReady = 1;
        cyc(); memRequestReady = 0; memResponseValid = 1;
        cyc(); memResponseValid = 0;
        cyc();

        // Randomized traffic against the transaction-level model
        outstanding = 0; issued = 0; dropped = 0; ownerI = 0; streak = 0;
        memPending = 0; memDelay = 0; iPend = 0; dPend = 0;
        expAddr = 0; expWd = 0; expWe = 0; expBe = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (!iPend && $urandom_range(2) == 0) begin
                iPend = 1; instrAddress = $urandom;
            end
            if (!dPend && $urandom_range(2) == 0) begin
                dPend = 1; dataAddress = $urandom; dataWriteEnable = 1'($urandom_range(1));
                dataWriteData = $urandom; dataByteEnable = 4'($urandom_range(15));
            end
            instrRequestValid = iPend;
            dataRequestValid = dPend;
            instrFlush = ($urandom_range(9) == 0);
            memRequestReady = 1'($urandom_range(1));
            if (memPending && memDelay == 0) begin
                memResponseValid = 1; memResponseData = $urandom;
            end else if (!memPending && $urandom_range(7) == 0) begin
                memResponseValid = 1; memResponseData = $urandom;
            end else begin
                memResponseValid = 0;
            end
            if (memPending && memDelay > 0) memDelay--;
            @(negedge clock);

            ivEff = instrRequestValid && !instrFlush;
            expIR = 0; expDR = 0;
            if (!outstanding) begin
                if (dataRequestValid && !(GUARD && streak == MAXS && ivEff)) expDR = 1;
                else if (ivEff) expIR = 1;
            end
            check("rnd_instrReady", instrRequestReady, expIR);
            check("rnd_dataReady", dataRequestReady, expDR);
            check("rnd_memReqValid", memRequestValid, outstanding && !issued);
            check("rnd_busy", busy, outstanding);

            respNow = outstanding && issued && memResponseValid;
            check("rnd_instrRespValid", instrResponseValid, respNow && ownerI && !(dropped || instrFlush));
            check("rnd_dataRespValid", dataResponseValid, respNow && !ownerI);
            if (respNow && ownerI && !(dropped || instrFlush))
                check("rnd_instrData", instrResponseData, memResponseData);
            if (respNow && !ownerI) check("rnd_dataData", dataResponseData, memResponseData);

            if (outstanding && !issued && memRequestReady) begin
                check("rnd_memFields", {memAddress, memWriteEnable, memWriteData, memByteEnable},
                      {expAddr, expWe, expWd, expBe});
                issued = 1;
            end
            if (outstanding && ownerI && instrFlush) dropped = 1;

            if (GUARD) begin
                if (expIR) streak = 0;
                else if (!outstanding && !instrRequestValid) streak = 0;
                else if (expDR && ivEff && streak < MAXS) streak++;
            end

            if (respNow) outstanding = 0;
            if (expDR) begin
                outstanding = 1; issued = 0; dropped = 0; ownerI = 0;
                expAddr = dataAddress; expWe = dataWriteEnable; expWd = dataWriteData; expBe = dataByteEnable;
            end else if (expIR) begin
                outstanding = 1; issued = 0; dropped = 0; ownerI = 1;
                expAddr = instrAddress; expWe = 0; expWd = 0; expBe = 0;
            end

            if (instrRequestReady) iPend = 0;
            if (dataRequestReady) dPend = 0;
            if (memPending && memResponseValid) memPending = 0;
            if (memRequestValid && memRequestReady) begin
                memPending = 1;
                memDelay = $urandom_range(2);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

- Shares the core's single memory port between the fetch stage (instruction requester) and the memory stage (data requester).
- One transaction is in flight at a time. Each accepted request is issued to memory, and the response is routed back to its owner.
- Data requests win over fetch by default. An optional streak guard bounds how long fetch can be starved.
- Sits between fetch/memory stages and the external memory interface; pipeline `stall` is derived from the requesters' `RequestReady`/`ResponseValid`.

## Interface
Parameters:
- `MAX_DATA_STREAK`, default 4: number of consecutive data grants with fetch pending before fetch is forced; used only when the guard is compiled in.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  core clock.
- `resetN`  in  1  asynchronous active-low reset.
- `instrRequestValid`  in  1  fetch request pending.
- `instrAddress`  in  32  fetch address.
- `instrFlush`  in  1  fetch flush; kills any pending or in-flight fetch.
- `instrRequestReady`  out  1  fetch request accepted this cycle.
- `instrResponseValid`  out  1  fetch data valid.
- `instrResponseData`  out  32  fetched instruction.
- `dataRequestValid`  in  1  load/store request pending.
- `dataAddress`  in  32  byte address.
- `dataWriteEnable`  in  1  1 = store.
- `dataWriteData`  in  32  store data.
- `dataByteEnable`  in  4  store lanes.
- `dataRequestReady`  out  1  data request accepted.
- `dataResponseValid`  out  1  load data or store acknowledge.
- `dataResponseData`  out  32  load data.
- `memRequestValid`  out  1  request to memory.
- `memRequestReady`  in  1  memory accepts the request.
- `memAddress`  out  32  registered request address.
- `memWriteEnable`  out  1  registered request write flag.
- `memWriteData`  out  32  registered request write data.
- `memByteEnable`  out  4  registered request byte lanes.
- `memResponseValid`  in  1  memory response; one per request, writes included.
- `memResponseData`  in  32  response data.
- `busy`  out  1  high whenever the state is not `ARB_IDLE`.

## Operation
States:
- `ARB_IDLE`:
  - Select a winner.
  - Assert that requester's `RequestReady` combinationally.
  - Latch its fields into the request registers.
  - Record the owner.
  - Go to `ARB_ISSUE`.
  - With no request pending, stay in `ARB_IDLE`.
- `ARB_ISSUE`:
  - `memRequestValid`=1 with registered fields held stable.
  - Move to `ARB_WAIT` on the cycle `memRequestReady`=1.
- `ARB_WAIT`:
  - On `memResponseValid`=1, drive the owner's `ResponseValid` for one cycle.
  - `ResponseData` = `memResponseData`.
  - Return to `ARB_IDLE`.

Winner selection:
- Data is chosen when `dataRequestValid`=1, otherwise instr.
- The guard (see Configuration) may override this.
- An instr request is never accepted in a cycle where `instrFlush`=1.

Handshake rules:
- A requester holds valid and all fields stable until its `RequestReady`.
- `RequestReady` is never asserted outside `ARB_IDLE`.
- At most one `RequestReady` is asserted per cycle.

Flush:
- `instrFlush`=1 while the owner is instr in `ARB_ISSUE` or `ARB_WAIT` sets a drop flag.
- The transaction still completes on the memory bus; memory is never abandoned mid-handshake.
- `instrResponseValid` stays 0 for that response.
- The drop flag clears on return to `ARB_IDLE`.
- A flush on the same cycle the response arrives also drops it.

Stray responses: `memResponseValid` in `ARB_IDLE` or `ARB_ISSUE` is ignored.

Reset values:
- State `ARB_IDLE`.
- All outputs 0, including the request registers and the drop flag.
- Streak counter 0.
- An asynchronous reset mid-transaction abandons it; any later stray response is ignored.

## Timing
- Request accepted in cycle N (`ARB_IDLE`).
- `memRequestValid` is high from N+1.
- With zero-wait memory (ready at N+1, response at N+2), the owner response is at N+2 and the state is `ARB_IDLE` at N+3.
- Minimum 3 cycles per transaction; throughput is 1 transaction per 3 cycles best case.
- The response path is combinational from `memResponseValid`/`memResponseData`; there is no added register stage.
- `busy` is registered and derived from state.

## Configuration
Macro `BUS_ARBITER_STREAK_GUARD_EN`.

When defined:
- The streak counter increments on each data grant made while `instrRequestValid`=1 and `instrFlush`=0.
- It clears on an instr grant, or in any `ARB_IDLE` cycle with no fetch request pending.
- When counter == `MAX_DATA_STREAK` and both requesters are pending, instr wins.
- The counter saturates at `MAX_DATA_STREAK`.

When undefined:
- Strict data priority; counter logic is absent.
- `MAX_DATA_STREAK` is ignored.

## Structure
- Shared package additions:
  - `arbiterState_` enum {`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`}.
  - `busOwner_` enum {`OWNER_INSTR`, `OWNER_DATA`}.
  - `memoryRequest_` packed struct {address, writeEnable, writeData, byteEnable}.
- One sub-module: `arbiter_streak_counter` (saturating counter with clear), instantiated only under the macro.

## Test plan
- Fetch only, zero-wait memory, `instrAddress`=0x80000000, response 0x00000013:
  - `instrRequestReady` at N, `memRequestValid` at N+1.
  - `instrResponseValid`=1 with data 0x00000013 at N+2; `busy` low at N+3.
- Both requesting at once:
  - Data granted first; fetch is granted at the next `ARB_IDLE` cycle.
  - `instrRequestReady`=0 during the data grant cycle.
- Store 0xDEADBEEF, byte enable 0xF, memory ready after 3 stall cycles:
  - `memWriteData`/`memByteEnable` stable throughout `ARB_ISSUE`.
  - `dataResponseValid` once, on the acknowledge.
- Fetch in flight, `instrFlush`=1 in `ARB_WAIT`:
  - Response 0x12345678 consumed.
  - `instrResponseValid` stays 0; next request is accepted normally.
- Guard on, `MAX_DATA_STREAK`=4, data and fetch valid continuously:
  - Grants D,D,D,D,I,D… repeating.
  - With the macro off, only D grants.
- Assert `resetN`=0 during `ARB_WAIT`, release, then pulse a stray `memResponseValid`:
  - All outputs 0.
  - No `ResponseValid` asserted.
  - State `ARB_IDLE`.
